// File: rtl/shift_issue_ctrl.sv
// -----------------------------------------------------------------------------
// shift_issue_ctrl
//
// Sequencing stage in front of the left/right barrel shifters. A decoded
// shift/rotate request is accepted, normalised into the shifters' control
// byte, and held stable while the shifters settle. The selected shifter output
// is then captured and handed to register-file writeback over a valid/ready
// handshake.
//
// This stage also covers the cases the shifters cannot handle directly:
//   - Left rotates are re-expressed as right rotates.
//   - Amounts above 8 are clamped for shifts and reduced mod 8 for rotates.
//   - Zero-amount requests bypass the shifters.
//   - Reserved modes are rejected with a one-cycle error pulse.
//
// Parameters
//   SETTLE_CYCLES  cycles the SH_* outputs are held before sampling (>= 1)
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_req_valid    request present
//   o_req_ready    high only while idle
//   i_req_dir      0 = left, 1 = right
//   i_req_mode     00 logical, 01 arithmetic, 10 rotate, 11 reserved
//   i_req_data     operand to shift
//   i_req_amount   unsigned shift amount
//   i_req_dest     destination register
//   o_sh_data1     operand to both shifters
//   o_sh_data2     control byte: [7:6] mode, [5:4] 0, [3:0] effective amount
//   o_sh_sel       1 = sample the right shifter, 0 = sample the left shifter
//   i_lsh_result   left shifter output
//   i_rsh_result   right shifter output
//   o_wb_valid     writeback data valid
//   i_wb_ready     register file accepts the writeback
//   o_wb_data      shifted result
//   o_wb_addr      latched destination register
//   o_err          one-cycle pulse when a reserved mode is rejected
// -----------------------------------------------------------------------------
module shift_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_dir,
    input  logic [1:0] i_req_mode,
    input  logic [7:0] i_req_data,
    input  logic [7:0] i_req_amount,
    input  logic [2:0] i_req_dest,
    output logic [7:0] o_sh_data1,
    output logic [7:0] o_sh_data2,
    output logic       o_sh_sel,
    input  logic [7:0] i_lsh_result,
    input  logic [7:0] i_rsh_result,
    output logic       o_wb_valid,
    input  logic       i_wb_ready,
    output logic [7:0] o_wb_data,
    output logic [2:0] o_wb_addr,
    output logic       o_err
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_RSV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WB
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_sh_data1;
    logic [7:0]       r_sh_data2;
    logic             r_sh_sel;
    logic             r_wb_valid;
    logic [7:0]       r_wb_data;
    logic [2:0]       r_wb_addr;
    logic             r_err;

    // Normalised view of the incoming request.
    logic [1:0] w_eff_mode;
    logic       w_eff_dir;
    logic [3:0] w_eff_amt;
    logic       w_is_rsv;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_eff_mode = i_req_mode;
        w_eff_dir  = i_req_dir;
        w_eff_amt  = 4'd0;
        w_is_rsv   = (i_req_mode == MODE_RSV);

        if (i_req_mode == MODE_ROT) begin
            // Rotates only care about amount mod 8. A left rotate by n equals
            // a right rotate by (8 - n) mod 8, which is just -n in 3 bits.
            w_eff_dir = 1'b1;
            if (i_req_dir) begin
                w_eff_amt = {1'b0, i_req_amount[2:0]};
            end else begin
                w_eff_amt = {1'b0, 3'(3'd0 - i_req_amount[2:0])};
            end
        end else begin
            // There is no left arithmetic shift; it is identical to logical.
            if (!i_req_dir && (i_req_mode == MODE_ARITH)) begin
                w_eff_mode = MODE_LOGIC;
            end
            // Anything from 8 upward flushes the whole operand.
            if (i_req_amount >= 8'd8) begin
                w_eff_amt = 4'd8;
            end else begin
                w_eff_amt = i_req_amount[3:0];
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sh_data1 <= 8'h00;
            r_sh_data2 <= 8'h00;
            r_sh_sel   <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= 8'h00;
            r_wb_addr  <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        if (w_is_rsv) begin
                            r_err <= 1'b1;
                        end else if (w_eff_amt == 4'd0) begin
                            // Nothing to shift: skip the shifters and leave
                            // SH_* untouched.
                            r_wb_addr  <= i_req_dest;
                            r_wb_data  <= i_req_data;
                            r_wb_valid <= 1'b1;
                            r_state    <= S_WB;
                        end else begin
                            r_wb_addr  <= i_req_dest;
                            r_sh_data1 <= i_req_data;
                            r_sh_data2 <= {w_eff_mode, 2'b00, w_eff_amt};
                            r_sh_sel   <= w_eff_dir;
                            r_cnt      <= '0;
                            r_state    <= S_SETTLE;
                        end
                    end
                end

                S_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_wb_data  <= r_sh_sel ? i_rsh_result : i_lsh_result;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_WB;
                    end
                end

                S_WB: begin
                    // Returning to idle here, rather than accepting directly,
                    // keeps a new request out of the completing cycle.
                    if (i_wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_sh_data1  = r_sh_data1;
    assign o_sh_data2  = r_sh_data2;
    assign o_sh_sel    = r_sh_sel;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_data   = r_wb_data;
    assign o_wb_addr   = r_wb_addr;
    assign o_err       = r_err;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_ctrl
//
// Bench for shift_issue_ctrl.
//
// A golden shifter pair drives the result inputs from the SH_* outputs. Its
// output is only trusted once the SH_* values have been stable long enough.
//
// Requests come from a vector table, plus hand-written sequences for
// writeback back-pressure and for reset in mid-flight. Expected writebacks are
// queued when a request is driven and compared when the handshake completes.
// -----------------------------------------------------------------------------
module tb_shift_issue_ctrl;

    localparam int SETTLE = 1;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_dir;
    logic [1:0] i_req_mode;
    logic [7:0] i_req_data;
    logic [7:0] i_req_amount;
    logic [2:0] i_req_dest;
    logic [7:0] o_sh_data1;
    logic [7:0] o_sh_data2;
    logic       o_sh_sel;
    logic [7:0] i_lsh_result;
    logic [7:0] i_rsh_result;
    logic       o_wb_valid;
    logic       i_wb_ready;
    logic [7:0] o_wb_data;
    logic [2:0] o_wb_addr;
    logic       o_err;

    shift_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_dir    (i_req_dir),
        .i_req_mode   (i_req_mode),
        .i_req_data   (i_req_data),
        .i_req_amount (i_req_amount),
        .i_req_dest   (i_req_dest),
        .o_sh_data1   (o_sh_data1),
        .o_sh_data2   (o_sh_data2),
        .o_sh_sel     (o_sh_sel),
        .i_lsh_result (i_lsh_result),
        .i_rsh_result (i_rsh_result),
        .o_wb_valid   (o_wb_valid),
        .i_wb_ready   (i_wb_ready),
        .o_wb_data    (o_wb_data),
        .o_wb_addr    (o_wb_addr),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- golden shifter model ----------------
    function automatic logic [7:0] lsh_f(input logic [7:0] d, input logic [7:0] c);
        logic [3:0] a;
        a = c[3:0];
        return (a >= 4'd8) ? 8'h00 : 8'(d << a);
    endfunction

    function automatic logic [7:0] rsh_f(input logic [7:0] d, input logic [7:0] c);
        logic [3:0]        a;
        logic signed [7:0] s;
        logic [15:0]       dd;
        a  = c[3:0];
        s  = d;
        dd = {d, d} >> a[2:0];
        case (c[7:6])
            2'b00:   return (a >= 4'd8) ? 8'h00 : (d >> a);
            2'b01:   return 8'(s >>> a);
            2'b10:   return dd[7:0];
            default: return d;
        endcase
    endfunction

    logic [7:0] m_sh1 = 8'h00;
    logic [7:0] m_sh2 = 8'h00;
    int         m_age = 0;

    always @(negedge i_clk) begin
        if (o_sh_data1 !== m_sh1 || o_sh_data2 !== m_sh2) begin
            m_sh1 <= o_sh_data1;
            m_sh2 <= o_sh_data2;
            m_age <= 0;
        end else if (m_age < 1000) begin
            m_age <= m_age + 1;
        end
    end

    // Unsettled shifters produce a recognisably wrong value.
    assign i_lsh_result = (m_age >= SETTLE - 1) ? lsh_f(m_sh1, m_sh2) : 8'hEE;
    assign i_rsh_result = (m_age >= SETTLE - 1) ? rsh_f(m_sh1, m_sh2) : 8'hEE;

    // ---------------- scoreboard ----------------
    logic [10:0] sb_q[$];

    always @(negedge i_clk) begin
        if (!i_reset && o_wb_valid && i_wb_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got data 0x%0h addr %0d, expected no writeback", o_wb_data, o_wb_addr);
            end else begin
                logic [10:0] e;
                e = sb_q.pop_front();
                check("sb_wb_data", o_wb_data, e[10:3]);
                check("sb_wb_addr", o_wb_addr, e[2:0]);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       dir;
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] amt;
        logic [2:0] dest;
        logic       err;
        logic       byp;
        logic [7:0] sh2;
        logic       sel;
        logic [7:0] wb;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic drive_req(input logic dir, input logic [1:0] mode, input logic [7:0] data,
                             input logic [7:0] amt, input logic [2:0] dest);
        i_req_valid  = 1'b1;
        i_req_dir    = dir;
        i_req_mode   = mode;
        i_req_data   = data;
        i_req_amount = amt;
        i_req_dest   = dest;
    endtask

    task automatic wait_ready();
        int waited = 0;
        @(negedge i_clk);
        while (!o_req_ready && waited < 50) begin
            @(negedge i_clk);
            waited++;
        end
        check("req_ready_before", o_req_ready, 1'b1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] p_sh1, p_sh2;
        logic       p_sel;
        int         waited;
        wait_ready();
        p_sh1 = o_sh_data1;
        p_sh2 = o_sh_data2;
        p_sel = o_sh_sel;
        drive_req(v.dir, v.mode, v.data, v.amt, v.dest);
        if (!v.err) sb_q.push_back({v.wb, v.dest});
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        if (v.err) begin
            check($sformatf("v%0d_err_hi", idx), o_err, 1'b1);
            check($sformatf("v%0d_err_ready", idx), o_req_ready, 1'b1);
            check($sformatf("v%0d_err_novalid", idx), o_wb_valid, 1'b0);
            @(posedge i_clk);
            #1;
            check($sformatf("v%0d_err_lo", idx), o_err, 1'b0);
            check($sformatf("v%0d_err_novalid2", idx), o_wb_valid, 1'b0);
        end else if (v.byp) begin
            check($sformatf("v%0d_byp_valid", idx), o_wb_valid, 1'b1);
            check($sformatf("v%0d_byp_data", idx), o_wb_data, v.wb);
            check($sformatf("v%0d_byp_sh", idx), {o_sh_data1, o_sh_data2, 7'd0, o_sh_sel},
                  {p_sh1, p_sh2, 7'd0, p_sel});
        end else begin
            check($sformatf("v%0d_sh1", idx), o_sh_data1, v.data);
            check($sformatf("v%0d_sh2", idx), o_sh_data2, v.sh2);
            check($sformatf("v%0d_sel", idx), o_sh_sel, v.sel);
            check($sformatf("v%0d_busy", idx), {o_req_ready, o_wb_valid}, 2'b00);
            repeat (SETTLE - 1) begin
                @(posedge i_clk);
                #1;
                check($sformatf("v%0d_early", idx), o_wb_valid, 1'b0);
            end
            @(posedge i_clk);
            #1;
            check($sformatf("v%0d_wb_valid", idx), o_wb_valid, 1'b1);
            check($sformatf("v%0d_wb_addr", idx), o_wb_addr, v.dest);
        end
        if (!v.err) begin
            waited = 0;
            while (o_wb_valid && waited < 50) begin
                @(posedge i_clk);
                #1;
                waited++;
            end
            check($sformatf("v%0d_wb_drop", idx), o_wb_valid, 1'b0);
            check($sformatf("v%0d_ready_after", idx), o_req_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            dir   mode   data   amt     dest  err   byp   sh2    sel   wb
        vecs[0]  = '{1'b1, 2'b01, 8'h90, 8'd2,   3'd1, 1'b0, 1'b0, 8'h42, 1'b1, 8'hE4};
        vecs[1]  = '{1'b0, 2'b00, 8'hFF, 8'd200, 3'd2, 1'b0, 1'b0, 8'h08, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 2'b10, 8'h81, 8'd3,   3'd3, 1'b0, 1'b0, 8'h85, 1'b1, 8'h0C};
        vecs[3]  = '{1'b1, 2'b10, 8'h5A, 8'd16,  3'd4, 1'b0, 1'b1, 8'h00, 1'b0, 8'h5A};
        vecs[4]  = '{1'b1, 2'b11, 8'h33, 8'd1,   3'd5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 2'b01, 8'h81, 8'd1,   3'd6, 1'b0, 1'b0, 8'h01, 1'b0, 8'h02};
        vecs[6]  = '{1'b1, 2'b00, 8'hF0, 8'd4,   3'd7, 1'b0, 1'b0, 8'h04, 1'b1, 8'h0F};
        vecs[7]  = '{1'b1, 2'b01, 8'h80, 8'd8,   3'd0, 1'b0, 1'b0, 8'h48, 1'b1, 8'hFF};
        vecs[8]  = '{1'b1, 2'b01, 8'h7F, 8'd255, 3'd1, 1'b0, 1'b0, 8'h48, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 2'b00, 8'h3C, 8'd0,   3'd2, 1'b0, 1'b1, 8'h00, 1'b0, 8'h3C};
        vecs[10] = '{1'b1, 2'b10, 8'h12, 8'd12,  3'd3, 1'b0, 1'b0, 8'h84, 1'b1, 8'h21};
        vecs[11] = '{1'b0, 2'b10, 8'h12, 8'd8,   3'd4, 1'b0, 1'b1, 8'h00, 1'b0, 8'h12};
        vecs[12] = '{1'b1, 2'b00, 8'hAA, 8'd8,   3'd5, 1'b0, 1'b0, 8'h08, 1'b1, 8'h00};
        vecs[13] = '{1'b0, 2'b10, 8'h01, 8'd7,   3'd6, 1'b0, 1'b0, 8'h81, 1'b1, 8'h80};

        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_dir    = 1'b0;
        i_req_mode   = 2'b00;
        i_req_data   = 8'h00;
        i_req_amount = 8'h00;
        i_req_dest   = 3'd0;
        i_wb_ready   = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_outputs", {o_sh_data1, o_sh_data2, o_wb_data, 3'd0, o_wb_addr, 4'd0,
                              o_sh_sel, o_wb_valid, o_err, o_req_ready}, 32'h0000_0001);
        i_reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Back-pressure: writeback held for 5 cycles must stay stable.
        wait_ready();
        i_wb_ready = 1'b0;
        drive_req(1'b1, 2'b00, 8'hC3, 8'd1, 3'd5);
        sb_q.push_back({8'h61, 3'd5});
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        check("bp_sh2", o_sh_data2, 8'h01);
        repeat (SETTLE) @(posedge i_clk);
        #1;
        check("bp_valid_rise", o_wb_valid, 1'b1);
        repeat (5) begin
            @(posedge i_clk);
            #1;
            check("bp_hold", {o_wb_valid, o_req_ready, o_wb_data, o_wb_addr}, {1'b1, 1'b0, 8'h61, 3'd5});
        end
        #1;
        i_wb_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_release", {o_wb_valid, o_req_ready}, 2'b01);

        // Reset while the request is still settling discards it.
        wait_ready();
        drive_req(1'b1, 2'b10, 8'hF0, 8'd3, 3'd7);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        check("rs_in_settle", {o_req_ready, o_wb_valid}, 2'b00);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        check("rs_outputs", {o_sh_data1, o_sh_data2, o_wb_data, 3'd0, o_wb_addr, 4'd0,
                             o_sh_sel, o_wb_valid, o_err, o_req_ready}, 32'h0000_0001);
        i_reset = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check("rs_no_wb", o_wb_valid, 1'b0);
        end
        run_vec(100, vecs[0]);

        repeat (3) @(posedge i_clk);
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
